// File: rtl/microwave_pkg.sv
// Shared types and default timing constants for the microwave controller.
// The DONE state only exists when MWCTRL_BEEP_EN is defined.
package microwave_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned BEEP_CYCLES_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2
`ifdef MWCTRL_BEEP_EN
        ,
        ST_DONE  = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for one active-low button.
// Emits a single-cycle press pulse; re-arms only after a stable release.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic clrn,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            pressed <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            // cnt runs while the synchronized level disagrees with the accepted one
            if (sync2 == pressed) begin
                if (cnt == LAST) begin
                    cnt     <= '0;
                    pressed <= !pressed;
                    press   <= !pressed;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven sequencing FSM with debounced start/stop buttons.
// Define MWCTRL_BEEP_EN to enable the DONE state and end-of-cook beep.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned BEEP_CYCLES     = BEEP_CYCLES_DEF
) (
    input  logic   clock,
    input  logic   clrn,
    input  logic   startn,
    input  logic   stopn,
    input  logic   door_closed,
    input  logic   timer_done,
    output logic   loadn,
    output logic   timer_en,
    output logic   timer_clrn,
    output logic   mag_on,
    output logic   beep,
    output state_t state_dbg
);

    if (DEBOUNCE_CYCLES < 1 || BEEP_CYCLES < 1) begin : g_bad_params
        $error("microwave_ctrl: DEBOUNCE_CYCLES and BEEP_CYCLES must be at least 1");
    end

    logic   start_p;
    logic   stop_p;
    state_t state;
    state_t next_state;
    logic   clear_req;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clock (clock),
        .clrn  (clrn),
        .btn_n (startn),
        .press (start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clock (clock),
        .clrn  (clrn),
        .btn_n (stopn),
        .press (stop_p)
    );

`ifdef MWCTRL_BEEP_EN
    localparam int unsigned   BW        = $clog2(BEEP_CYCLES) + 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
    logic [BW-1:0] beep_cnt;
`endif

    // Stop always beats start; in COOK an open door beats timer_done beats stop.
    always_comb begin
        next_state = state;
        clear_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stop_p)
                    clear_req = 1'b1;
                else if (start_p && door_closed && !timer_done)
                    next_state = ST_COOK;
            end
            ST_COOK: begin
                if (!door_closed)
                    next_state = ST_PAUSE;
                else if (timer_done)
`ifdef MWCTRL_BEEP_EN
                    next_state = ST_DONE;
`else
                    next_state = ST_IDLE;
`endif
                else if (stop_p)
                    next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop_p) begin
                    next_state = ST_IDLE;
                    clear_req  = 1'b1;
                end else if (start_p && door_closed) begin
                    next_state = ST_COOK;
                end
            end
`ifdef MWCTRL_BEEP_EN
            ST_DONE: begin
                if (stop_p || beep_cnt == BEEP_LAST)
                    next_state = ST_IDLE;
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state      <= ST_IDLE;
            loadn      <= 1'b0;
            timer_en   <= 1'b0;
            timer_clrn <= 1'b1;
            mag_on     <= 1'b0;
`ifdef MWCTRL_BEEP_EN
            beep       <= 1'b0;
            beep_cnt   <= '0;
`endif
        end else begin
            state      <= next_state;
            loadn      <= (next_state != ST_IDLE);
            timer_en   <= (next_state == ST_COOK);
            timer_clrn <= !clear_req;
            mag_on     <= (next_state == ST_COOK);
`ifdef MWCTRL_BEEP_EN
            beep       <= (next_state == ST_DONE);
            beep_cnt   <= (state == ST_DONE) ? beep_cnt + BW'(1) : '0;
`endif
        end
    end

`ifndef MWCTRL_BEEP_EN
    assign beep = 1'b0;
`endif

    assign state_dbg = state;

endmodule
